// File: rtl/ram_wait_ctrl_pkg.sv
// Shared encodings for the wait-state RAM controller: transfer sizes, direction and FSM states.
// Also holds the alignment fault rule used when a request is accepted.
package ram_wait_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Misaligned half/word or the reserved size encoding.
  function automatic logic is_fault(input logic [1:0] addr_lo, input logic [1:0] size);
    logic f;
    case (size)
      SIZE_BYTE: f = 1'b0;
      SIZE_HALF: f = addr_lo[0];
      SIZE_WORD: f = |addr_lo;
      SIZE_RSVD: f = 1'b1;
      default:   f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ram_wait_ctrl_byte_lane_steer.sv
// Combinational byte-lane steering: maps a right-justified datum of 1/2/4 bytes onto the four
// byte lanes of the addressed word (lane i = byte at word base + i) and back, honouring endianness.
module ram_wait_ctrl_byte_lane_steer
  import ram_wait_ctrl_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rlanes,
  output logic [3:0]  wmask,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  logic [2:0] nbytes_s;

  // Transfer size in bytes; the reserved encoding touches no lane.
  always_comb begin
    case (size)
      SIZE_BYTE: nbytes_s = 3'd1;
      SIZE_HALF: nbytes_s = 3'd2;
      SIZE_WORD: nbytes_s = 3'd4;
      SIZE_RSVD: nbytes_s = 3'd0;
      default:   nbytes_s = 3'd0;
    endcase
  end

  // Byte k of the transfer sits in lane addr_lo+k; its significance depends on endianness.
  always_comb begin
    int k_s;
    int sig_s;
    wmask  = 4'b0000;
    wlanes = 32'h0000_0000;
    rdata  = 32'h0000_0000;
    k_s    = 0;
    sig_s  = 0;
    for (int i = 0; i < 4; i++) begin
      k_s = i - int'(addr_lo);
      if (k_s >= 0 && k_s < int'(nbytes_s)) begin
        sig_s = BIG_ENDIAN ? (int'(nbytes_s) - 1 - k_s) : k_s;
        wmask[i]            = 1'b1;
        wlanes[8*i +: 8]    = wdata[8*sig_s +: 8];
        rdata[8*sig_s +: 8] = rlanes[8*i +: 8];
      end else begin
        wmask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_wait_ctrl.sv
// Byte-addressed data memory with programmable wait states and an MFA/MFC four-phase handshake.
// Requests are latched at accept; faulted requests skip the wait count and never touch memory.
module ram_wait_ctrl
  import ram_wait_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MFA,
  input  logic              RW_RAM,
  input  logic [1:0]        DataSize,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              MFE,
  output logic              BUSY
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t            state_r, state_next_s;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              rw_r;
  logic [31:0]       wdata_r;
  logic              fault_r;
  logic [31:0]       data_out_r;
  logic              mfc_r, mfe_r, busy_r;
  logic [7:0]        mem_r [DEPTH];

  logic              accept_s, commit_s, countdown_s, fault_s;
  logic [ADDR_W-1:0] base_s;
  logic [31:0]       rlanes_s, wlanes_s, rdata_s;
  logic [3:0]        wmask_s;

  assign base_s  = {addr_r[ADDR_W-1:2], 2'b00};
  assign fault_s = is_fault(Address[1:0], DataSize);

  // Gather the four bytes of the addressed word as lanes.
  always_comb begin
    rlanes_s = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      rlanes_s[8*i +: 8] = mem_r[base_s + ADDR_W'(i)];
    end
  end

  ram_wait_ctrl_byte_lane_steer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_steer (
    .addr_lo(addr_r[1:0]),
    .size   (size_r),
    .wdata  (wdata_r),
    .rlanes (rlanes_s),
    .wmask  (wmask_s),
    .wlanes (wlanes_s),
    .rdata  (rdata_s)
  );

  // Next-state logic; dropping MFA in WAIT abandons the access even on the commit edge.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    commit_s     = 1'b0;
    countdown_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MFA) begin
          state_next_s = ST_WAIT;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!MFA) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_next_s = ST_ACK;
          commit_s     = !fault_r;
        end else begin
          state_next_s = ST_WAIT;
          countdown_s  = 1'b1;
        end
      end
      ST_ACK: begin
        if (!MFA) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACK;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, request latches, counter and registered handshake outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= '0;
      size_r     <= SIZE_BYTE;
      rw_r       <= RW_READ;
      wdata_r    <= 32'h0000_0000;
      fault_r    <= 1'b0;
      data_out_r <= 32'h0000_0000;
      mfc_r      <= 1'b0;
      mfe_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      mfc_r   <= (state_next_s == ST_ACK);
      mfe_r   <= (state_next_s == ST_ACK) && fault_r;
      busy_r  <= (state_next_s != ST_IDLE);
      if (accept_s) begin
        addr_r  <= Address;
        size_r  <= DataSize;
        rw_r    <= RW_RAM;
        wdata_r <= DataIn;
        fault_r <= fault_s;
        cnt_r   <= fault_s ? 4'd0 : WAIT_INIT;
      end else if (countdown_s) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (commit_s && rw_r == RW_READ) begin
        data_out_r <= rdata_s;
      end
    end
  end

  // Byte array: contents survive reset; only enabled lanes are written.
  always_ff @(posedge CLK) begin
    if (commit_s && rw_r == RW_WRITE) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem_r[base_s + ADDR_W'(i)] <= wlanes_s[8*i +: 8];
        end
      end
    end
  end

  assign DataOut = data_out_r;
  assign MFC     = mfc_r;
  assign MFE     = mfe_r;
  assign BUSY    = busy_r;

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Self-checking bench for ram_wait_ctrl: directed handshake scenarios plus random traffic
// compared against a byte-array reference model.
module tb_ram_wait_ctrl;

  localparam int ADDR_W = 8;
  localparam int WS     = 2;
  localparam bit BE     = 1'b1;
  localparam int DEPTH  = 256;

  logic        CLK = 1'b0;
  logic        CLR, MFA, RW_RAM;
  logic [1:0]  DataSize;
  logic [7:0]  Address;
  logic [31:0] DataIn, DataOut;
  logic        MFC, MFE, BUSY;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] exp_dout;

  always #5 CLK = ~CLK;

  ram_wait_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS), .BIG_ENDIAN(BE)) dut (
    .CLK(CLK), .CLR(CLR), .MFA(MFA), .RW_RAM(RW_RAM), .DataSize(DataSize),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MFE(MFE), .BUSY(BUSY)
  );

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    if (s == 2'd2) return 4;
    return 0;
  endfunction

  function automatic bit faulty(input int a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] model_read(input int a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (BE) r = (r << 8) | 32'(ref_mem[(a + k) % DEPTH]);
      else    r = r | (32'(ref_mem[(a + k) % DEPTH]) << (8 * k));
    end
    return r;
  endfunction

  task automatic model_write(input int a, input int n, input logic [31:0] d);
    int sh;
    for (int k = 0; k < n; k++) begin
      sh = BE ? 8 * (n - 1 - k) : 8 * k;
      ref_mem[(a + k) % DEPTH] = 8'(d >> sh);
    end
  endtask

  // One complete handshake; inputs are scrambled after accept to prove they were latched.
  task automatic txn(input string tag, input logic rw, input logic [1:0] size, input int addr,
                     input logic [31:0] wd, input int hold);
    bit f;
    int lat;
    int exp_lat;
    f       = faulty(addr, size);
    exp_lat = f ? 2 : WS + 2;
    @(negedge CLK);
    MFA = 1'b1; RW_RAM = rw; DataSize = size; Address = 8'(addr); DataIn = wd;
    lat = 40;
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLK);
      if (e == 1) check(tag, "busy", 32'(BUSY), 32'd1);
      RW_RAM = 1'($urandom); DataSize = 2'($urandom); Address = 8'($urandom); DataIn = $urandom;
      if (MFC === 1'b1) begin
        lat = e;
        break;
      end
    end
    if (!f) begin
      if (rw) exp_dout = model_read(addr, nbytes(size));
      else    model_write(addr, nbytes(size), wd);
    end
    check(tag, "latency", 32'(lat), 32'(exp_lat));
    check(tag, "mfe", 32'(MFE), 32'(f));
    check(tag, "dout", DataOut, exp_dout);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check(tag, "mfc_hold", 32'(MFC), 32'd1);
      check(tag, "dout_hold", DataOut, exp_dout);
    end
    MFA = 1'b0;
    @(negedge CLK);
    check(tag, "mfc_clr", 32'(MFC), 32'd0);
    check(tag, "mfe_clr", 32'(MFE), 32'd0);
    check(tag, "busy_clr", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int a;
    logic [1:0] s;
    CLR = 1'b0; MFA = 1'b0; RW_RAM = 1'b1; DataSize = 2'd0; Address = 8'h00; DataIn = 32'h0;
    exp_dout = 32'h0;
    repeat (2) @(negedge CLK);
    check("reset", "dout", DataOut, 32'h0);
    check("reset", "mfc", 32'(MFC), 32'd0);
    check("reset", "mfe", 32'(MFE), 32'd0);
    check("reset", "busy", 32'(BUSY), 32'd0);
    CLR = 1'b1;

    for (int w = 0; w < DEPTH / 4; w++) txn("fill", 1'b0, 2'd2, 4 * w, $urandom, 0);

    txn("t1_wr", 1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 0);
    txn("t1_rd", 1'b1, 2'd2, 32'h10, 32'h0, 0);
    check("t1", "value", DataOut, 32'hDEADBEEF);
    txn("t2_byte", 1'b1, 2'd0, 32'h11, 32'h0, 0);
    check("t2", "byte", DataOut, 32'h000000AD);
    txn("t2_half", 1'b1, 2'd1, 32'h12, 32'h0, 0);
    check("t2", "half", DataOut, 32'h0000BEEF);
    txn("t3_wr", 1'b0, 2'd0, 32'h13, 32'h00000055, 0);
    txn("t3_rd", 1'b1, 2'd2, 32'h10, 32'h0, 0);
    check("t3", "value", DataOut, 32'hDEADBE55);

    txn("t4_mis", 1'b1, 2'd2, 32'h11, 32'h0, 0);
    txn("t4_rsvd", 1'b1, 2'd3, 32'h10, 32'h0, 0);
    txn("t4_wmis", 1'b0, 2'd1, 32'h11, 32'h12345678, 0);
    txn("t4_rd", 1'b1, 2'd2, 32'h10, 32'h0, 0);
    check("t4", "value", DataOut, 32'hDEADBE55);

    txn("t5_pre", 1'b1, 2'd2, 32'h20, 32'h0, 0);
    @(negedge CLK);
    MFA = 1'b1; RW_RAM = 1'b0; DataSize = 2'd2; Address = 8'h20; DataIn = ~exp_dout;
    @(negedge CLK);
    MFA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t5_abort", "mfc", 32'(MFC), 32'd0);
    end
    check("t5_abort", "busy", 32'(BUSY), 32'd0);
    check("t5_abort", "dout", DataOut, exp_dout);
    @(negedge CLK);
    MFA = 1'b1; RW_RAM = 1'b0; DataSize = 2'd2; Address = 8'h20; DataIn = ~exp_dout;
    @(negedge CLK);
    CLR = 1'b0;
    #2;
    check("t5_clr", "busy", 32'(BUSY), 32'd0);
    check("t5_clr", "dout", DataOut, 32'h0);
    MFA = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    exp_dout = 32'h0;
    repeat (3) begin
      @(negedge CLK);
      check("t5_clr", "mfc", 32'(MFC), 32'd0);
    end
    txn("t5_rd", 1'b1, 2'd2, 32'h20, 32'h0, 0);

    txn("t6_rd", 1'b1, 2'd2, 32'h10, 32'h0, 5);
    txn("t6_wr", 1'b0, 2'd2, 32'h24, 32'hCAFEF00D, 5);
    txn("t6_chk", 1'b1, 2'd2, 32'h24, 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, DEPTH - 1);
      if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a - (a % nbytes(s));
      txn("rand", 1'($urandom), s, a, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
